// File: rtl/div_sched.sv
// Round-robin scheduler for two signed divide requesters. Each accepted op makes 32 passes
// through one external restoring divide stage, and the scheduler applies sign correction.
module div_sched #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [31:0] req0_num,
   input  logic [31:0] req0_den,
   input  logic [31:0] req1_num,
   input  logic [31:0] req1_den,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [31:0] rsp_quot,
   output logic [31:0] rsp_rem,
   output logic        rsp_err,
   output logic        busy,
   output logic [31:0] st_A,
   output logic [31:0] st_B,
   output logic [31:0] st_R,
   output logic [31:0] st_Q,
   output logic [4:0]  st_count,
   output logic        st_v,
   input  logic [31:0] st_A_next,
   input  logic [31:0] st_B_next,
   input  logic [31:0] st_R_next,
   input  logic [31:0] st_Q_next,
   input  logic [4:0]  st_count_out,
   input  logic        st_vout
);
   localparam int unsigned W  = 32;
   localparam int unsigned CW = 5;
   localparam int unsigned TW = 5;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_FIX   = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   logic [2:0]    state, state_n;
   logic          ptr, ptr_n;
   logic          id, id_n;
   logic          sn, sn_n, sd, sd_n;
   logic          err, err_n;
   logic [TW-1:0] tmo, tmo_n;
   logic [W-1:0]  a_n, b_n, r_n, q_n;
   logic [CW-1:0] cnt_n;
   logic          v_n, busy_n;
   logic          rsp_valid_n, rsp_id_n, rsp_err_n;
   logic [W-1:0]  quot_n, rem_n;

   logic          grant1, accept, op_bad;
   logic [W-1:0]  num_s, den_s, num_abs, den_abs;

   // Arbitration, operand screening and next-state logic
   always_comb begin
      state_n     = state;
      ptr_n       = ptr;
      id_n        = id;
      sn_n        = sn;
      sd_n        = sd;
      err_n       = err;
      tmo_n       = tmo;
      a_n         = st_A;
      b_n         = st_B;
      r_n         = st_R;
      q_n         = st_Q;
      cnt_n       = st_count;
      v_n         = 1'b0;
      rsp_valid_n = 1'b0;
      rsp_id_n    = rsp_id;
      rsp_err_n   = rsp_err;
      quot_n      = rsp_quot;
      rem_n       = rsp_rem;

      grant1     = req1_valid & (~req0_valid | ptr);
      accept     = rst & (state == S_IDLE) & (req0_valid | req1_valid);
      req0_ready = accept & ~grant1;
      req1_ready = accept & grant1;
      num_s      = grant1 ? req1_num : req0_num;
      den_s      = grant1 ? req1_den : req0_den;
      num_abs    = num_s[W-1] ? W'(-num_s) : num_s;
      den_abs    = den_s[W-1] ? W'(-den_s) : den_s;
      // The stage compares signed 2R+1 against B, so B must stay within 2^30
      op_bad     = (den_s == '0) | (num_s == {1'b1, {(W-1){1'b0}}}) |
                   (den_abs > W'(32'h4000_0000));

      case (state)
         S_IDLE: begin
            if (accept) begin
               id_n  = grant1;
               ptr_n = ~grant1;
               sn_n  = num_s[W-1];
               sd_n  = den_s[W-1];
               err_n = op_bad;
               // Bad operands still pass through FIX so every response has the same tail
               if (op_bad) begin
                  state_n = S_FIX;
               end else begin
                  a_n     = num_abs;
                  b_n     = den_abs;
                  r_n     = '0;
                  q_n     = '0;
                  cnt_n   = '0;
                  v_n     = 1'b1;
                  state_n = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            tmo_n   = '0;
            state_n = S_WAIT;
         end
         S_WAIT: begin
            if (st_vout) begin
               a_n   = st_A_next;
               b_n   = st_B_next;
               r_n   = st_R_next;
               q_n   = st_Q_next;
               cnt_n = st_count_out;
               if (st_count_out == '0) begin
                  state_n = S_FIX;
               end else begin
                  v_n     = 1'b1;
                  state_n = S_ISSUE;
               end
            end else if (tmo == TW'(TIMEOUT - 1)) begin
               err_n   = 1'b1;
               state_n = S_FIX;
            end else begin
               tmo_n = tmo + TW'(1);
            end
         end
         S_FIX: begin
            rsp_valid_n = 1'b1;
            rsp_id_n    = id;
            rsp_err_n   = err;
            quot_n      = err ? '0 : ((sn ^ sd) ? W'(-st_Q) : st_Q);
            rem_n       = err ? '0 : (sn ? W'(-st_R) : st_R);
            state_n     = S_RESP;
         end
         S_RESP: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      busy_n = (state_n != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         ptr       <= 1'b0;
         id        <= 1'b0;
         sn        <= 1'b0;
         sd        <= 1'b0;
         err       <= 1'b0;
         tmo       <= '0;
         st_A      <= '0;
         st_B      <= '0;
         st_R      <= '0;
         st_Q      <= '0;
         st_count  <= '0;
         st_v      <= 1'b0;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_quot  <= '0;
         rsp_rem   <= '0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         id        <= id_n;
         sn        <= sn_n;
         sd        <= sd_n;
         err       <= err_n;
         tmo       <= tmo_n;
         st_A      <= a_n;
         st_B      <= b_n;
         st_R      <= r_n;
         st_Q      <= q_n;
         st_count  <= cnt_n;
         st_v      <= v_n;
         busy      <= busy_n;
         rsp_valid <= rsp_valid_n;
         rsp_id    <= rsp_id_n;
         rsp_err   <= rsp_err_n;
         rsp_quot  <= quot_n;
         rsp_rem   <= rem_n;
      end
   end

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a behavioural restoring-divide stage of fixed latency.
module tb_div_sched;
   localparam int unsigned STAGE_LAT = 4;
   localparam int unsigned TIMEOUT   = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0] req0_num, req0_den, req1_num, req1_den;
   logic        rsp_valid, rsp_id, rsp_err, busy;
   logic [31:0] rsp_quot, rsp_rem;
   logic [31:0] st_A, st_B, st_R, st_Q;
   logic [4:0]  st_count;
   logic        st_v;
   logic [31:0] st_A_next, st_B_next, st_R_next, st_Q_next;
   logic [4:0]  st_count_out;
   logic        st_vout;

   logic        mute, late;
   int          total = 0;
   int          bad = 0;
   int          stv_cnt = 0;
   int          rsp_cnt = 0;
   int          base_stv;
   int          lat;

   always #5 clk = ~clk;

   div_sched #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_num(req0_num), .req0_den(req0_den),
      .req1_num(req1_num), .req1_den(req1_den),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_quot(rsp_quot), .rsp_rem(rsp_rem),
      .rsp_err(rsp_err), .busy(busy),
      .st_A(st_A), .st_B(st_B), .st_R(st_R), .st_Q(st_Q), .st_count(st_count), .st_v(st_v),
      .st_A_next(st_A_next), .st_B_next(st_B_next), .st_R_next(st_R_next), .st_Q_next(st_Q_next),
      .st_count_out(st_count_out), .st_vout(st_vout)
   );

   // Behavioural stage: one restoring step, delayed STAGE_LAT cycles
   typedef struct packed {
      logic        v;
      logic [4:0]  cnt;
      logic [31:0] a, b, r, q;
   } stage_t;

   stage_t pipe [STAGE_LAT];

   function automatic stage_t step(input logic v, input logic [4:0] cnt,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] r, input logic [31:0] q);
      stage_t s;
      logic [31:0] r2;
      r2    = {r[30:0], a[31]};
      s.v   = v;
      s.cnt = cnt + 5'd1;
      s.a   = {a[30:0], 1'b0};
      s.b   = b;
      if (r2 >= b) begin
         s.r = r2 - b;
         s.q = {q[30:0], 1'b1};
      end else begin
         s.r = r2;
         s.q = {q[30:0], 1'b0};
      end
      return s;
   endfunction

   always @(posedge clk) begin
      pipe[0] <= step(st_v, st_count, st_A, st_B, st_R, st_Q);
      for (int i = 1; i < STAGE_LAT; i++) pipe[i] <= pipe[i-1];
      if (st_v) stv_cnt <= stv_cnt + 1;
      if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
   end

   assign st_vout      = (pipe[STAGE_LAT-1].v & ~mute) | late;
   assign st_A_next    = pipe[STAGE_LAT-1].a;
   assign st_B_next    = pipe[STAGE_LAT-1].b;
   assign st_R_next    = pipe[STAGE_LAT-1].r;
   assign st_Q_next    = pipe[STAGE_LAT-1].q;
   assign st_count_out = pipe[STAGE_LAT-1].cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // Present a request and wait (bounded) for its ready strobe
   task automatic send(input int id, input logic [31:0] num, input logic [31:0] den);
      int guard = 0;
      @(negedge clk);
      if (id == 0) begin
         req0_valid = 1'b1; req0_num = num; req0_den = den;
      end else begin
         req1_valid = 1'b1; req1_num = num; req1_den = den;
      end
      #1;
      while (!(id == 0 ? req0_ready : req1_ready) && guard < 400) begin
         @(negedge clk); #1;
         guard++;
      end
      check("ready", 32'(id == 0 ? req0_ready : req1_ready), 32'd1);
      base_stv = stv_cnt;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
      end while (!rsp_valid && n < 400);
   endtask

   task automatic do_op(input string name, input int id, input logic [31:0] num,
                        input logic [31:0] den, input logic [31:0] eq, input logic [31:0] er,
                        input logic eerr, input int exp_lat, input int exp_pulses,
                        output int n);
      send(id, num, den);
      wait_rsp(n);
      check({name, ".rsp_seen"}, 32'(rsp_valid), 32'd1);
      if (exp_lat >= 0) check({name, ".lat"}, 32'(n), 32'(exp_lat));
      check({name, ".id"}, 32'(rsp_id), 32'(id));
      check({name, ".quot"}, rsp_quot, eq);
      check({name, ".rem"}, rsp_rem, er);
      check({name, ".err"}, 32'(rsp_err), 32'(eerr));
      check({name, ".pulses"}, 32'(stv_cnt - base_stv), 32'(exp_pulses));
      @(negedge clk);
      check({name, ".one_cycle"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      int rsp_base;
      int guard;
      rst = 1'b0; mute = 1'b0; late = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_num = '0; req0_den = '0; req1_num = '0; req1_den = '0;
      repeat (3) @(negedge clk);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst.st_v", 32'(st_v), 32'd0);
      check("rst.st_A", st_A, 32'd0);
      check("rst.quot", rsp_quot, 32'd0);
      rst = 1'b1;

      do_op("pos",  0,  100,  7,  14,  2, 1'b0, 162, 32, lat);
      do_op("negn", 1, -100,  7, -14, -2, 1'b0, 162, 32, lat);
      do_op("negd", 1,  100, -7, -14,  2, 1'b0, 162, 32, lat);
      do_op("den0", 0,    5,  0,   0,  0, 1'b1,   2,  0, lat);
      do_op("minn", 0, 32'h8000_0000, 3, 0, 0, 1'b1, 2, 0, lat);
      do_op("bigd", 1,    5, 32'h4000_0001, 0, 0, 1'b1, 2, 0, lat);
      do_op("edge", 0, 32'h4000_0000, 32'h4000_0000, 1, 0, 1'b0, 162, 32, lat);

      // Stage never answers: abort after TIMEOUT WAIT cycles, then a stray st_vout in IDLE
      mute = 1'b1;
      do_op("tmo", 0, 77, 5, 0, 0, 1'b1, -1, 1, lat);
      check("tmo.lat", 32'(lat >= int'(TIMEOUT) + 1 && lat <= int'(TIMEOUT) + 8), 32'd1);
      mute = 1'b0;
      @(negedge clk); late = 1'b1;
      @(negedge clk); late = 1'b0;
      @(negedge clk);
      check("late.busy", 32'(busy), 32'd0);
      do_op("after", 1, 9, 3, 3, 0, 1'b0, 162, 32, lat);

      // Reset in the middle of pass 10
      send(0, 100, 7);
      guard = 0;
      while (stv_cnt - base_stv < 10 && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      check("mid.reached", 32'(stv_cnt - base_stv), 32'd10);
      rst = 1'b0; req0_valid = 1'b0;
      rsp_base = rsp_cnt;
      @(negedge clk);
      check("mid.busy", 32'(busy), 32'd0);
      check("mid.st_v", 32'(st_v), 32'd0);
      check("mid.rsp_valid", 32'(rsp_valid), 32'd0);
      rst = 1'b1;
      repeat (200) @(negedge clk);
      check("mid.no_rsp", 32'(rsp_cnt - rsp_base), 32'd0);
      do_op("r50", 0, 50, 5, 10, 0, 1'b0, 162, 32, lat);

      // Both requesters held valid from reset: grants must alternate
      @(negedge clk);
      rst = 1'b0;
      req0_valid = 1'b1; req0_num = 20; req0_den = 4;
      req1_valid = 1'b1; req1_num = 21; req1_den = -5;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
         end while (!rsp_valid && lat < 400);
         if (k == 3) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
         check("rr.seen", 32'(rsp_valid), 32'd1);
         check("rr.id", 32'(rsp_id), 32'(k % 2));
         check("rr.quot", rsp_quot, (k % 2 == 0) ? 32'd5 : -32'sd4);
         check("rr.rem", rsp_rem, (k % 2 == 0) ? 32'd0 : 32'd1);
      end
      repeat (3) @(negedge clk);
      check("rr.idle", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div_sched.md
# div_sched

Two-requester scheduler and sequencer for the single-bit restoring divide stage in the LPC coefficient path. It accepts signed 32-bit divide requests from two clients (e.g. reflection-coefficient and error-update units) and arbitrates between them round-robin. Each accepted operation is recirculated through one external divide-stage instance for 32 passes. The scheduler applies sign correction and returns quotient/remainder with the requester ID; only one operation is in flight.

## Interface
- STAGE_LAT, 4: cycles from st_v sampled high to st_vout high; used only by verification as the latency contract.
- TIMEOUT, 16: max WAIT cycles per pass before the operation aborts with error.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- req0_valid / req1_valid  in  1  request pending.
- req0_ready / req1_ready  out  1  accept strobe; combinational, high only in IDLE for the granted requester.
- req0_num / req1_num  in  32  signed dividend.
- req0_den / req1_den  in  32  signed divisor.
- rsp_valid  out  1  one-cycle result pulse.
- rsp_id  out  1  requester index of the result.
- rsp_quot / rsp_rem  out  32  signed quotient / remainder.
- rsp_err  out  1  operand error or stage timeout.
- busy  out  1  high in every state except IDLE.
- st_A, st_B, st_R, st_Q  out  32  stage operand inputs.
- st_count  out  5  stage pass counter input.
- st_v  out  1  stage input valid, one-cycle pulse.
- st_A_next, st_B_next, st_R_next, st_Q_next  in  32  stage outputs.
- st_count_out  in  5  stage pass counter output (input count + 1, mod 32).
- st_vout  in  1  stage output valid.

## Operation
- FSM states: IDLE, ISSUE, WAIT, FIX, RESP.
- IDLE:
  - Grant round-robin. A last-grant pointer favours the requester not served last; after reset it favours req0.
  - When both requesters are valid, the favoured one wins. The loser's valid stays pending and is granted next.
  - On grant: raise reqN_ready, capture num/den, and compute sn = num[31], sd = den[31], |num|, |den|.
- Operand error (rsp_err=1, quot=rem=0, go to RESP):
  - den == 0
  - num == 32'h8000_0000
  - |den| > 2^30 (the stage compares signed 2R+1 against B)
- Otherwise go to ISSUE with A=|num|, B=|den|, R=0, Q=0, count=0.
- ISSUE: st_v=1 for one cycle with the held operand registers. Clear the timeout counter. Go to WAIT.
- WAIT:
  - st_v=0; timeout counter increments each cycle.
  - On st_vout: latch A/B/R/Q/count from the st_*_next inputs.
  - If st_count_out == 0 (32nd pass, counter wrap), go to FIX; otherwise go to ISSUE.
  - If the counter reaches TIMEOUT without st_vout: rsp_err=1, quot=rem=0, go to RESP.
- FIX:
  - quot = (sn^sd) ? -Q : Q.
  - rem = sn ? -R : R (truncating division; remainder takes the dividend's sign).
- RESP: rsp_valid=1 for one cycle with rsp_id = granted index. Go to IDLE; requests are not accepted in this cycle.
- st_vout outside WAIT is ignored.
- Reset values:
  - All outputs 0, st_* outputs 0.
  - State IDLE, pointer = favour req0, timeout counter 0.

## Timing
- Accept (cycle 0):
  - Cycle 1: ISSUE.
  - Cycle 1+STAGE_LAT: st_vout.
  - Next cycle: ISSUE again.
  - Pass period = 1+STAGE_LAT = 5 cycles.
- Result: rsp_valid in cycle 2 + 32·(1+STAGE_LAT) = 162 after accept. Error responses come at cycle 2.
- Back-to-back: next accept no earlier than the cycle after RESP. Throughput is 1 op per 163 cycles.
- Requester may drop valid before accept without effect. Data must be held stable only in the ready cycle.
- rst low mid-operation: the next cycle is IDLE, st_v=0, and no rsp_valid is generated for the aborted op.

## Test plan
- req0 num=100 den=7 with a behavioural 4-cycle stage model -> rsp_valid at cycle 162 after accept, id=0, quot=14, rem=2, err=0; exactly 32 st_v pulses.
- req1 num=-100 den=7; then num=100 den=-7 -> quot=-14 rem=-2; then quot=-14 rem=2.
- Operand errors: den=0; num=32'h8000_0000; den=2^30+1 -> each gives err=1, quot=rem=0, rsp at cycle 2, no st_v; den=2^30 with num=2^30 -> quot=1, rem=0.
- Both valid continuously from reset -> grants alternate 0,1,0,1; each id matches its operands; no request starved.
- Stage model never returns st_vout -> err=1 after TIMEOUT WAIT cycles; a late st_vout afterwards has no effect on a following 9/3 op (quot=3, rem=0).
- rst low at pass 10 -> IDLE next cycle, busy=0, no rsp; a new 50/5 request then completes with quot=10.
